party_select_fsm: RTL and testbench
===================================

PARTY_SELECT_FSM -- requirements
Module: party_select_fsm

Interface
REQ-001 Parameters (name, default, meaning):
- N_COLS, 4, chooser grid columns.
- N_ROWS, 2, chooser grid rows.
- TEAM_SIZE, 3, party slots.
- ID_W, 3, choice-ID width; N_COLS*N_ROWS <= 2**ID_W.
- ROAM_CYCLES, 16, ROAM dwell in clocks before a battle, >= 1.
REQ-002 Ports (name, direction, width, meaning):
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-high reset.
- keycode  in  8  current USB keycode; 0 = no key.
- end_battle  in  1  battle-complete pulse.
- result  in  1  battle outcome, 1 = win; sampled with end_battle.
- state  out  2  00 START, 01 ROAM, 10 BATTLE, 11 END.
- is_start, is_battle, is_end  out  1 each  one-hot decodes of state.
- cur_choice  out  ID_W  cursor index = row*N_COLS + col.
- team  out  TEAM_SIZE*ID_W  slot k at bits [k*ID_W +: ID_W].
- num_chosen  out  $clog2(TEAM_SIZE+1)  filled slot count.
- team_full  out  1  num_chosen == TEAM_SIZE.
- dup_err  out  1  one-cycle pulse on a rejected duplicate pick.

Function
REQ-003 Key codes: W=8'h1A, A=8'h04, S=8'h16, D=8'h07, ENTER=8'h28, BKSP=8'h2A.
REQ-004 Press event: keycode != 0 and keycode != the previous cycle's registered keycode.
- A held key yields exactly one event.
- All key actions below act only on press events.
REQ-005 All outputs are registered; every action is visible the cycle after its press event.
REQ-006 Cursor moves, START only:
- A/D: col -/+ 1, wrapping within the row.
- W/S: row -/+ 1, wrapping within the column.
REQ-007 ENTER in START, team not full, cur_choice absent from filled slots:
- team[num_chosen] <= cur_choice.
- num_chosen increments.
REQ-008 ENTER in START, team not full, cur_choice already in a filled slot:
- team and num_chosen unchanged.
- dup_err pulses for one cycle.
REQ-009 BKSP in START with num_chosen > 0:
- num_chosen decrements.
- The vacated slot clears to 0.
- BKSP with num_chosen == 0 is ignored.
REQ-010 START -> ROAM on ENTER press when team_full; cursor and team are held.
REQ-011 ROAM -> BATTLE when the dwell counter reaches ROAM_CYCLES-1.
- The counter clears on ROAM entry.
- ROAM therefore lasts exactly ROAM_CYCLES clocks.
REQ-012 BATTLE exit on end_battle: result=1 -> ROAM; result=0 -> END.
REQ-013 end_battle outside BATTLE is ignored.
REQ-014 END -> START on W press.
- team, num_chosen and cur_choice clear on the transition.
- All other keys in END are ignored.
REQ-015 Keys other than those in REQ-003 have no effect; letter keys in ROAM/BATTLE have no effect.

Reset
REQ-016 Reset clears all of the following:
- state=START, cur_choice=0, team=0, num_chosen=0.
- dup_err=0, dwell counter=0, previous-keycode register=0.
REQ-017 Reset mid-operation takes priority over every event in the same cycle.
- The block returns to START on the next edge.

Verification
REQ-018 Default parameters, cursor at 3, press D -> cur_choice=0; press S -> cur_choice=4; press W -> cur_choice=0.
REQ-019 Pick sequence with one duplicate -> team slots {2,5,7}, team_full=1, one dup_err pulse:
- ENTER at cursor 2, ENTER at cursor 5.
- ENTER at cursor 2 again (duplicate).
- ENTER at cursor 7.
REQ-020 Hold ENTER for 10 cycles at cursor 1 from empty -> num_chosen=1 only.
REQ-021 Full team, ENTER -> ROAM for exactly 16 cycles, then BATTLE.
- end_battle=1 with result=1 -> ROAM.
- Next battle: end_battle=1 with result=0 -> END.
- W press -> START with team=0.
REQ-022 Three picks, then BKSP twice -> num_chosen=1 and slots 1-2 are 0.
- Assert Reset during ROAM -> all outputs at their reset values one cycle later.

Source files
------------

// File: rtl/party_select_fsm.sv
// rtl/party_select_fsm.sv - party chooser / roam / battle game-state controller
// Keyboard-driven cursor and team picker feeding a roam-battle loop.
module party_select_fsm #(
  parameter int N_COLS      = 4,
  parameter int N_ROWS      = 2,
  parameter int TEAM_SIZE   = 3,
  parameter int ID_W        = 3,
  parameter int ROAM_CYCLES = 16
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic [7:0]                     keycode,
  input  logic                           end_battle,
  input  logic                           result,
  output logic [1:0]                     state,
  output logic                           is_start,
  output logic                           is_battle,
  output logic                           is_end,
  output logic [ID_W-1:0]                cur_choice,
  output logic [TEAM_SIZE*ID_W-1:0]      team,
  output logic [$clog2(TEAM_SIZE+1)-1:0] num_chosen,
  output logic                           team_full,
  output logic                           dup_err
);

  localparam int NC_W  = $clog2(TEAM_SIZE + 1);
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_W = (ROAM_CYCLES > 1) ? $clog2(ROAM_CYCLES) : 1;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;

  typedef enum logic [1:0] {
    ST_START  = 2'b00,
    ST_ROAM   = 2'b01,
    ST_BATTLE = 2'b10,
    ST_END    = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_prev_key;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic [ID_W-1:0]  r_cur, w_cur_nxt;
  logic [ID_W-1:0]  r_team [TEAM_SIZE];
  logic [ID_W-1:0]  w_team_nxt [TEAM_SIZE];
  logic [NC_W-1:0]  r_num, w_num_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dup, w_dup_nxt;
  logic             r_full;
  logic             r_is_start, r_is_battle, r_is_end;
  logic             w_press;
  logic             w_dup_hit;

  // A held key produces a single event: only a change to a nonzero code counts.
  assign w_press = (keycode != 8'h00) && (keycode != r_prev_key);

  always_comb begin
    w_dup_hit = 1'b0;
    for (int k = 0; k < TEAM_SIZE; k++) begin
      if ((NC_W'(k) < r_num) && (r_team[k] == r_cur)) w_dup_hit = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_num_nxt   = r_num;
    w_cnt_nxt   = '0;
    w_dup_nxt   = 1'b0;
    w_team_nxt  = r_team;
    case (r_state)
      ST_START: begin
        if (w_press) begin
          case (keycode)
            KEY_A: w_col_nxt = (r_col == '0) ? COL_W'(N_COLS - 1) : r_col - 1'b1;
            KEY_D: w_col_nxt = (r_col == COL_W'(N_COLS - 1)) ? '0 : r_col + 1'b1;
            KEY_W: w_row_nxt = (r_row == '0) ? ROW_W'(N_ROWS - 1) : r_row - 1'b1;
            KEY_S: w_row_nxt = (r_row == ROW_W'(N_ROWS - 1)) ? '0 : r_row + 1'b1;
            KEY_ENTER: begin
              if (r_full) begin
                w_state_nxt = ST_ROAM;
              end else if (w_dup_hit) begin
                w_dup_nxt = 1'b1;
              end else begin
                for (int k = 0; k < TEAM_SIZE; k++) begin
                  if (NC_W'(k) == r_num) w_team_nxt[k] = r_cur;
                end
                w_num_nxt = r_num + 1'b1;
              end
            end
            KEY_BKSP: begin
              if (r_num != '0) begin
                for (int k = 0; k < TEAM_SIZE; k++) begin
                  if (NC_W'(k) == (r_num - 1'b1)) w_team_nxt[k] = '0;
                end
                w_num_nxt = r_num - 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ROAM: begin
        // Counter starts at 0 on entry, so ROAM is held for exactly ROAM_CYCLES clocks.
        if (r_cnt == CNT_W'(ROAM_CYCLES - 1)) w_state_nxt = ST_BATTLE;
        else                                  w_cnt_nxt   = r_cnt + 1'b1;
      end
      ST_BATTLE: begin
        if (end_battle) w_state_nxt = result ? ST_ROAM : ST_END;
      end
      ST_END: begin
        if (w_press && (keycode == KEY_W)) begin
          w_state_nxt = ST_START;
          w_col_nxt   = '0;
          w_row_nxt   = '0;
          w_num_nxt   = '0;
          for (int k = 0; k < TEAM_SIZE; k++) w_team_nxt[k] = '0;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
    w_cur_nxt = ID_W'(w_row_nxt) * ID_W'(N_COLS) + ID_W'(w_col_nxt);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_START;
      r_prev_key  <= 8'h00;
      r_col       <= '0;
      r_row       <= '0;
      r_cur       <= '0;
      r_num       <= '0;
      r_cnt       <= '0;
      r_dup       <= 1'b0;
      r_full      <= 1'b0;
      r_is_start  <= 1'b1;
      r_is_battle <= 1'b0;
      r_is_end    <= 1'b0;
      for (int k = 0; k < TEAM_SIZE; k++) r_team[k] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_prev_key  <= keycode;
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_cur       <= w_cur_nxt;
      r_num       <= w_num_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dup       <= w_dup_nxt;
      r_full      <= (w_num_nxt == NC_W'(TEAM_SIZE));
      r_is_start  <= (w_state_nxt == ST_START);
      r_is_battle <= (w_state_nxt == ST_BATTLE);
      r_is_end    <= (w_state_nxt == ST_END);
      r_team      <= w_team_nxt;
    end
  end

  always_comb begin
    team = '0;
    for (int k = 0; k < TEAM_SIZE; k++) team[k*ID_W +: ID_W] = r_team[k];
  end

  assign state      = r_state;
  assign is_start   = r_is_start;
  assign is_battle  = r_is_battle;
  assign is_end     = r_is_end;
  assign cur_choice = r_cur;
  assign num_chosen = r_num;
  assign team_full  = r_full;
  assign dup_err    = r_dup;

endmodule

// File: tb/tb_party_select_fsm.sv
// tb/tb_party_select_fsm.sv - scoreboard bench for party_select_fsm
// Stimulus queues expected snapshots; a negedge monitor pops and compares them.
module tb_party_select_fsm;

  localparam logic [7:0] KW = 8'h1A, KA = 8'h04, KS = 8'h16, KD = 8'h07;
  localparam logic [7:0] KENT = 8'h28, KBK = 8'h2A;

  logic       Clk, Reset, end_battle, result;
  logic [7:0] keycode;
  logic [1:0] state;
  logic       is_start, is_battle, is_end, team_full, dup_err;
  logic [2:0] cur_choice;
  logic [8:0] team;
  logic [1:0] num_chosen;

  party_select_fsm dut (
    .Clk(Clk), .Reset(Reset), .keycode(keycode), .end_battle(end_battle),
    .result(result), .state(state), .is_start(is_start), .is_battle(is_battle),
    .is_end(is_end), .cur_choice(cur_choice), .team(team),
    .num_chosen(num_chosen), .team_full(team_full), .dup_err(dup_err)
  );

  typedef struct {
    string      name;
    int         at;
    logic [1:0] st;
    logic [2:0] cur;
    logic [8:0] tm;
    logic [1:0] num;
    int         dups;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   dups_seen = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    exp_t e;
    if (dup_err === 1'b1) dups_seen++;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (state !== e.st || cur_choice !== e.cur || team !== e.tm ||
          num_chosen !== e.num || team_full !== (e.num == 2'd3) ||
          is_start !== (e.st == 2'b00) || is_battle !== (e.st == 2'b10) ||
          is_end !== (e.st == 2'b11) || dup_err !== 1'b0 || dups_seen != e.dups) begin
        n_errors++;
        $display("FAIL %s: got st=%b cur=%0d team=%h num=%0d full=%b one_hot=%b%b%b dup=%b dups=%0d; exp st=%b cur=%0d team=%h num=%0d dups=%0d",
                 e.name, state, cur_choice, team, num_chosen, team_full, is_start,
                 is_battle, is_end, dup_err, dups_seen, e.st, e.cur, e.tm, e.num, e.dups);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
    tick();
  endtask

  task automatic chk(input string nm, input logic [1:0] st, input logic [2:0] cur,
                     input logic [8:0] tm, input logic [1:0] num, input int dups);
    exp_t e;
    e.name = nm; e.at = cyc; e.st = st; e.cur = cur;
    e.tm = tm; e.num = num; e.dups = dups;
    q.push_back(e);
  endtask

  initial begin
    Reset = 1'b1; keycode = 8'h00; end_battle = 1'b0; result = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    chk("reset", 2'b00, 3'd0, 9'h000, 2'd0, 0);

    repeat (3) press(KD);
    chk("cursor_3", 2'b00, 3'd3, 9'h000, 2'd0, 0);
    press(KD); chk("d_wrap", 2'b00, 3'd0, 9'h000, 2'd0, 0);
    press(KS); chk("s_down", 2'b00, 3'd4, 9'h000, 2'd0, 0);
    press(KW); chk("w_up", 2'b00, 3'd0, 9'h000, 2'd0, 0);
    press(KA); chk("a_wrap", 2'b00, 3'd3, 9'h000, 2'd0, 0);
    press(KW); chk("w_wrap", 2'b00, 3'd7, 9'h000, 2'd0, 0);
    press(KS); press(KA);
    press(KENT); chk("pick2", 2'b00, 3'd2, 9'h002, 2'd1, 0);
    press(KS); press(KA);
    press(KENT); chk("pick5", 2'b00, 3'd5, 9'h02A, 2'd2, 0);
    press(KW); press(KD);
    press(KENT); chk("dup2", 2'b00, 3'd2, 9'h02A, 2'd2, 1);
    press(KS); press(KD);
    press(KENT); chk("pick7", 2'b00, 3'd7, 9'h1EA, 2'd3, 1);

    keycode = KENT; tick();
    chk("roam_enter", 2'b01, 3'd7, 9'h1EA, 2'd3, 1);
    keycode = 8'h00;
    repeat (15) tick();
    chk("roam_last", 2'b01, 3'd7, 9'h1EA, 2'd3, 1);
    tick();
    chk("battle1", 2'b10, 3'd7, 9'h1EA, 2'd3, 1);
    end_battle = 1'b1; result = 1'b1; tick(); end_battle = 1'b0;
    chk("win_roam", 2'b01, 3'd7, 9'h1EA, 2'd3, 1);
    end_battle = 1'b1; result = 1'b0; tick(); end_battle = 1'b0;
    chk("eb_ignored", 2'b01, 3'd7, 9'h1EA, 2'd3, 1);
    repeat (15) tick();
    chk("battle2", 2'b10, 3'd7, 9'h1EA, 2'd3, 1);
    press(KD); chk("key_in_battle", 2'b10, 3'd7, 9'h1EA, 2'd3, 1);
    end_battle = 1'b1; result = 1'b0; tick(); end_battle = 1'b0;
    chk("lose_end", 2'b11, 3'd7, 9'h1EA, 2'd3, 1);
    press(KS); chk("end_ignore", 2'b11, 3'd7, 9'h1EA, 2'd3, 1);
    press(KW); chk("end_to_start", 2'b00, 3'd0, 9'h000, 2'd0, 1);

    press(KD);
    keycode = KENT; tick();
    chk("hold_first", 2'b00, 3'd1, 9'h001, 2'd1, 1);
    repeat (9) tick();
    keycode = 8'h00; tick();
    chk("hold_10", 2'b00, 3'd1, 9'h001, 2'd1, 1);

    press(KD); press(KENT);
    press(KD); press(KENT);
    chk("three", 2'b00, 3'd3, 9'h0D1, 2'd3, 1);
    press(KBK); press(KBK);
    chk("bksp2", 2'b00, 3'd3, 9'h001, 2'd1, 1);
    press(KBK); chk("bksp_empty", 2'b00, 3'd3, 9'h000, 2'd0, 1);
    press(KBK); chk("bksp_ignored", 2'b00, 3'd3, 9'h000, 2'd0, 1);

    press(KENT); press(KA); press(KENT); press(KA); press(KENT);
    chk("refill", 2'b00, 3'd1, 9'h053, 2'd3, 1);
    press(KENT); repeat (3) tick();
    chk("roam_pre_rst", 2'b01, 3'd1, 9'h053, 2'd3, 1);
    Reset = 1'b1; keycode = KD; end_battle = 1'b1; result = 1'b1;
    tick();
    chk("reset_roam", 2'b00, 3'd0, 9'h000, 2'd0, 1);
    Reset = 1'b0; end_battle = 1'b0;
    tick();
    chk("post_rst_key", 2'b00, 3'd1, 9'h000, 2'd0, 1);
    keycode = 8'h00;
    tick();

    for (int i = 0; i < 5 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
